// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter with locked bursts in front of
// the byte-addressed data memory. Misaligned accesses are kept off the memory
// and reported through a registered per-port response one cycle after grant.
module dmem_arbiter #(
  parameter int unsigned WA       = 32,
  parameter int unsigned WD       = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [2:0]    funct3_0,
  input  logic [2:0]    funct3_1,
  input  logic [WA-1:0] addr0,
  input  logic [WA-1:0] addr1,
  input  logic [WD-1:0] wdata0,
  input  logic [WD-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [WD-1:0] rdata0,
  output logic [WD-1:0] rdata1,
  output logic          err0,
  output logic          err1,
  output logic [WA-1:0] mem_addr,
  output logic          mem_we,
  output logic [2:0]    mem_funct3,
  output logic [WD-1:0] mem_wdata,
  input  logic [WD-1:0] mem_rdata
);

  localparam int unsigned   CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q;     // 1: port 1 was granted most recently
  logic          rvalid0_q, rvalid1_q;
  logic          err0_q, err1_q;
  logic [WD-1:0] rdata0_q, rdata1_q;
  logic          mis0, mis1;
  logic          hold0, hold1;

  // Sizes 011/110/111 fall into the default (word) branch.
  function automatic logic misaligned(input logic [2:0] f, input logic [1:0] a);
    logic m;
    case (f[1:0])
      2'b00:   m = 1'b0;
      2'b01:   m = a[0];
      default: m = |a;
    endcase
    return m;
  endfunction

  // Count restarts when ownership changes hands; it only advances while the
  // other port is actually being held off, and saturates at LOCK_MAX.
  function automatic logic [CW-1:0] lock_count(input logic          owned,
                                               input logic [CW-1:0] cnt,
                                               input logic          other_req);
    logic [CW-1:0] c;
    c = owned ? cnt : '0;
    if (other_req && (c != CNT_MAX)) c = c + 1'b1;
    return c;
  endfunction

  assign mis0  = misaligned(funct3_0, addr0[1:0]);
  assign mis1  = misaligned(funct3_1, addr1[1:0]);
  assign hold0 = (owner_q == OWN_P0) && req0 && (cnt_q < CNT_MAX);
  assign hold1 = (owner_q == OWN_P1) && req1 && (cnt_q < CNT_MAX);

  // Grant: unexpired lock owner first, otherwise round-robin on last winner.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (hold0) begin
        gnt0 = 1'b1;
      end else if (hold1) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Memory-side mux; idle cycles drive zeros and misaligned stores are dropped.
  always_comb begin
    mem_addr   = '0;
    mem_funct3 = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    if (gnt0) begin
      mem_addr   = addr0;
      mem_funct3 = funct3_0;
      mem_wdata  = wdata0;
      mem_we     = we0 & ~mis0;
    end else if (gnt1) begin
      mem_addr   = addr1;
      mem_funct3 = funct3_1;
      mem_wdata  = wdata1;
      mem_we     = we1 & ~mis1;
    end
  end

  // Next lock owner and burst count from this cycle's grant.
  always_comb begin
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (gnt0) begin
      owner_d = lock0 ? OWN_P0 : OWN_NONE;
      cnt_d   = lock0 ? lock_count(owner_q == OWN_P0, cnt_q, req1) : '0;
    end else if (gnt1) begin
      owner_d = lock1 ? OWN_P1 : OWN_NONE;
      cnt_d   = lock1 ? lock_count(owner_q == OWN_P1, cnt_q, req0) : '0;
    end
  end

  // Arbitration state and registered per-port responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      last_q    <= 1'b1;
      owner_q   <= OWN_NONE;
      cnt_q     <= '0;
    end else begin
      rvalid0_q <= gnt0;
      rvalid1_q <= gnt1;
      if (gnt0) begin
        rdata0_q <= (!we0 && !mis0) ? mem_rdata : '0;
        err0_q   <= mis0;
      end
      if (gnt1) begin
        rdata1_q <= (!we1 && !mis1) ? mem_rdata : '0;
        err1_q   <= mis1;
      end
      if (gnt0 || gnt1) begin
        last_q  <= gnt1;
        owner_q <= owner_d;
        cnt_q   <= cnt_d;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus against dmem_arbiter with a byte-array
// memory, a rule-level reference model checked every cycle, and literal checks.
module tb_dmem_arbiter;

  localparam int LM = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [2:0]  funct3_0, funct3_1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_funct3;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [256];

  dmem_arbiter #(.WA(32), .WD(32), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .funct3_0(funct3_0), .funct3_1(funct3_1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f);
    case (f)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic misal(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    return (int'(a[7:0]) % sz) != 0;
  endfunction

  // Combinational memory read
  always_comb begin
    logic [7:0] i;
    i = mem_addr[7:0];
    mem_rdata = ext({mem[i + 8'd3], mem[i + 8'd2], mem[i + 8'd1], mem[i]}, mem_funct3);
  end

  // Memory preload and posedge writes
  initial begin
    logic [7:0] wi;
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
    forever begin
      @(posedge clk);
      if (mem_we) begin
        wi = mem_addr[7:0];
        mem[wi] <= mem_wdata[7:0];
        if (mem_funct3[1:0] != 2'b00) mem[wi + 8'd1] <= mem_wdata[15:8];
        if (mem_funct3[1] == 1'b1) begin
          mem[wi + 8'd2] <= mem_wdata[23:16];
          mem[wi + 8'd3] <= mem_wdata[31:24];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: arbitration rules applied to plain integer state
  int          m_last, m_owner, m_cnt;
  logic        e_rv [2];
  logic        e_err [2];
  logic [31:0] e_rd [2];

  always @(negedge clk) begin
    logic        pr [2];
    logic        pl [2];
    logic        pw [2];
    logic [2:0]  pf [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [7:0]  bi;
    logic        ms;
    int          win;
    if (!rst_n) begin
      m_last = 1; m_owner = -1; m_cnt = 0;
      for (int p = 0; p < 2; p++) begin
        e_rv[p] = 1'b0; e_err[p] = 1'b0; e_rd[p] = '0;
      end
      chk("rst_gnt", {gnt0, gnt1}, 0);
      chk("rst_rsp", {rvalid0, rvalid1, err0, err1}, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      chk("rst_mem", {mem_we, mem_funct3} | mem_addr | mem_wdata, 0);
    end else begin
      pr[0] = req0; pl[0] = lock0; pw[0] = we0; pf[0] = funct3_0; pa[0] = addr0; pd[0] = wdata0;
      pr[1] = req1; pl[1] = lock1; pw[1] = we1; pf[1] = funct3_1; pa[1] = addr1; pd[1] = wdata1;

      chk("rvalid0", rvalid0, e_rv[0]);
      chk("rvalid1", rvalid1, e_rv[1]);
      chk("rdata0", rdata0, e_rd[0]);
      chk("rdata1", rdata1, e_rd[1]);
      chk("err0", err0, e_err[0]);
      chk("err1", err1, e_err[1]);

      win = -1;
      if (pr[0] && pr[1]) begin
        if (m_owner >= 0 && m_cnt < LM) win = m_owner;
        else win = 1 - m_last;
      end else if (pr[0]) win = 0;
      else if (pr[1]) win = 1;

      chk("gnt0", gnt0, win == 0);
      chk("gnt1", gnt1, win == 1);
      if (win >= 0) begin
        chk("mem_addr", mem_addr, pa[win]);
        chk("mem_funct3", mem_funct3, pf[win]);
        chk("mem_wdata", mem_wdata, pd[win]);
        chk("mem_we", mem_we, pw[win] && !misal(pf[win], pa[win]));
      end else begin
        chk("idle_mem", {mem_we, mem_funct3} | mem_addr | mem_wdata, 0);
      end

      for (int p = 0; p < 2; p++) begin
        e_rv[p] = (win == p);
        if (win == p) begin
          ms = misal(pf[p], pa[p]);
          bi = pa[p][7:0];
          e_err[p] = ms;
          e_rd[p] = (!pw[p] && !ms)
                    ? ext({mem[bi + 8'd3], mem[bi + 8'd2], mem[bi + 8'd1], mem[bi]}, pf[p])
                    : 32'h0;
        end
      end
      if (win >= 0) begin
        if (pl[win]) begin
          if (m_owner != win) m_cnt = 0;
          if (pr[1 - win] && m_cnt < LM) m_cnt++;
          m_owner = win;
        end else begin
          m_owner = -1;
          m_cnt = 0;
        end
        m_last = win;
      end
    end
  end

  task automatic p0(input logic r, input logic l, input logic w, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d);
    req0 = r; lock0 = l; we0 = w; funct3_0 = f; addr0 = a; wdata0 = d;
  endtask

  task automatic p1(input logic r, input logic l, input logic w, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d);
    req1 = r; lock1 = l; we1 = w; funct3_1 = f; addr1 = a; wdata1 = d;
  endtask

  task automatic idle();
    p0(0, 0, 0, 3'b000, 32'h0, 32'h0);
    p1(0, 0, 0, 3'b000, 32'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence with literal expectations
  initial begin
    int g [20];
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rvalid", {rvalid0, rvalid1}, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_err", {err0, err1}, 0);

    // lw 0x10 from port 0
    step(); p0(1, 0, 0, 3'b010, 32'h10, 32'h0);
    @(negedge clk); chk("lw_gnt0", gnt0, 1);
    step(); idle();
    @(negedge clk);
    chk("lw_rvalid0", rvalid0, 1);
    chk("lw_rdata0", rdata0, 32'hDEADBEEF);
    chk("lw_err0", err0, 0);

    // Both requesting, no lock: port 0 won last, so 1,0,1,0,...
    step(); p0(1, 0, 0, 3'b010, 32'h10, 32'h0); p1(1, 0, 0, 3'b010, 32'h14, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g[i] = gnt1 ? 1 : (gnt0 ? 0 : -1);
      chk("alt_grant", g[i], 32'(((i % 2) == 0) ? 1 : 0));
      if (i > 0) chk("alt_rvalid1", rvalid1, 32'(((i % 2) == 1) ? 1 : 0));
      step();
    end

    // Port 1 locked, port 0 always requesting: 8 grants to 1, one to 0, repeat
    p0(1, 0, 0, 3'b010, 32'h10, 32'h0); p1(1, 1, 0, 3'b010, 32'h14, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      g[i] = gnt1 ? 1 : (gnt0 ? 0 : -1);
      chk("lock_grant", g[i], 32'((i == 8 || i == 17) ? 0 : 1));
      step();
    end
    idle();

    // Misaligned sw: blocked from memory, flagged
    step(); p0(1, 0, 1, 3'b010, 32'h22, 32'h12345678);
    @(negedge clk);
    chk("sw_mis_gnt0", gnt0, 1);
    chk("sw_mis_mem_we", mem_we, 0);
    step(); idle();
    @(negedge clk);
    chk("sw_mis_rvalid0", rvalid0, 1);
    chk("sw_mis_err0", err0, 1);
    chk("sw_mis_rdata0", rdata0, 0);
    for (int i = 0; i < 4; i++) chk("sw_mis_mem", mem[8'(32'h22 + i)], pat(32'h22 + i));

    // sh from port 1, lhu / lh from port 0
    step(); p1(1, 0, 1, 3'b001, 32'h40, 32'h0000ABCD);
    step(); idle(); p0(1, 0, 0, 3'b101, 32'h40, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("lhu_rvalid0", rvalid0, 1);
    chk("lhu_rdata0", rdata0, 32'h0000ABCD);
    step(); p1(1, 0, 1, 3'b001, 32'h40, 32'h00008001);
    step(); idle(); p0(1, 0, 0, 3'b001, 32'h40, 32'h0);
    step(); idle();
    @(negedge clk); chk("lh_rdata0", rdata0, 32'hFFFF8001);

    // funct3 110 treated as word for alignment; lb at odd address is fine
    step(); p1(1, 0, 0, 3'b110, 32'h42, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("f110_err1", err1, 1);
    chk("f110_rdata1", rdata1, 0);
    step(); p1(1, 0, 0, 3'b000, 32'h43, 32'h0);
    step(); idle();
    @(negedge clk);
    chk("lb_err1", err1, 0);
    chk("lb_rdata1", rdata1, 32'hFFFFFFD8);

    // Reset in the cycle after a grant discards the response
    step(); p0(1, 0, 0, 3'b010, 32'h10, 32'h0);
    @(negedge clk); chk("rstmid_gnt0", gnt0, 1);
    step(); idle(); rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_rvalid0", rvalid0, 0);
    chk("rstmid_rdata0", rdata0, 0);
    step(); step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rstrel_rvalid0", rvalid0, 0);
    chk("rstrel_rdata", rdata0 | rdata1, 0);
    chk("rstrel_err", {err0, err1}, 0);

    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
